// File: rtl/countdown_display_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | countdown_display_ctrl_if                                                |
// | Control inputs and display outputs of the countdown display controller.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface countdown_display_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    start;
  logic                    pause;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] static_bcd;
  logic [NUM_DIGITS-1:0]   led_en;
  logic [7:0]              seg;
  logic                    running;
  logic                    done;

  modport master (
    output start, pause, clear, static_bcd,
    input  led_en, seg, running, done
  );

  modport slave (
    input  start, pause, clear, static_bcd,
    output led_en, seg, running, done
  );
endinterface
`default_nettype wire

// File: rtl/countdown_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | countdown_display_ctrl                                                   |
// | Two-digit BCD countdown with start/pause/clear, multiplexed 7-seg scan.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module countdown_display_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCND_CNT_MAX = 100_000_000,
  parameter int SCAN_CNT_MAX = 200_000,
  parameter int CNT_START    = 10,
  parameter bit AUTO_RELOAD  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  countdown_display_ctrl_if.slave bus
);

  localparam int         c_scnd_w     = $clog2(SCND_CNT_MAX);
  localparam int         c_scan_w     = $clog2(SCAN_CNT_MAX);
  localparam logic [c_scnd_w-1:0] c_scnd_last = c_scnd_w'(SCND_CNT_MAX - 1);
  localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_CNT_MAX - 1);
  localparam logic [2:0] c_pos_tens   = 3'(NUM_DIGITS - 1);
  localparam logic [2:0] c_pos_ones   = 3'(NUM_DIGITS - 2);
  localparam logic [3:0] c_start_tens = 4'(CNT_START / 10);
  localparam logic [3:0] c_start_ones = 4'(CNT_START % 10);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_ctl_s, r_ctl_q, w_ev;
  logic [c_scnd_w-1:0]   r_scnd_cnt, w_scnd_nxt;
  logic [c_scan_w-1:0]   r_scan_cnt;
  logic [2:0]            r_scan_pos;
  logic [3:0]            r_tens, r_ones, w_tens_nxt, w_ones_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_tick;
  logic [3:0]            w_digit;
  logic [NUM_DIGITS-1:0] r_led_en;
  logic [7:0]            r_seg;

  // Bit order {clear, pause, start}; an event is the first registered high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl_s <= 3'b000;
      r_ctl_q <= 3'b000;
    end else begin
      r_ctl_s <= {bus.clear, bus.pause, bus.start};
      r_ctl_q <= r_ctl_s;
    end
  end

  assign w_ev   = r_ctl_s & ~r_ctl_q;
  assign w_tick = (r_scnd_cnt == c_scnd_last);

  always_comb begin
    w_state_nxt = r_state;
    w_scnd_nxt  = r_scnd_cnt;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_scnd_nxt = '0;
        w_tens_nxt = c_start_tens;
        w_ones_nxt = c_start_ones;
        if (w_ev[0]) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_scnd_nxt = w_tick ? '0 : r_scnd_cnt + c_scnd_w'(1);
        if (w_ev[1]) w_state_nxt = ST_PAUSE;
        if (w_tick) begin
          if (r_tens == 4'd0 && r_ones == 4'd0) begin
            w_done_nxt = 1'b1;
            if (AUTO_RELOAD) begin
              w_tens_nxt = c_start_tens;
              w_ones_nxt = c_start_ones;
            end else begin
              // Terminal tick without reload lands in DONE even if paused
              w_state_nxt = ST_DONE;
            end
          end else if (r_ones == 4'd0) begin
            w_ones_nxt = 4'd9;
            w_tens_nxt = r_tens - 4'd1;
          end else begin
            w_ones_nxt = r_ones - 4'd1;
          end
        end
      end
      ST_PAUSE: begin
        if (w_ev[1]) w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (w_ev[0]) begin
          w_state_nxt = ST_RUN;
          w_scnd_nxt  = '0;
          w_tens_nxt  = c_start_tens;
          w_ones_nxt  = c_start_ones;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_ev[2]) begin
      w_state_nxt = ST_IDLE;
      w_scnd_nxt  = '0;
      w_tens_nxt  = c_start_tens;
      w_ones_nxt  = c_start_ones;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_scnd_cnt <= '0;
      r_tens     <= c_start_tens;
      r_ones     <= c_start_ones;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_scnd_cnt <= w_scnd_nxt;
      r_tens     <= w_tens_nxt;
      r_ones     <= w_ones_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_scan_pos <= 3'd0;
    end else if (r_state == ST_IDLE) begin
      r_scan_cnt <= '0;
      r_scan_pos <= 3'd0;
    end else if (r_scan_cnt == c_scan_last) begin
      r_scan_cnt <= '0;
      r_scan_pos <= (r_scan_pos == c_pos_tens) ? 3'd0 : r_scan_pos + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + c_scan_w'(1);
    end
  end

  always_comb begin
    w_digit = 4'hf;
    if (r_scan_pos == c_pos_tens)      w_digit = r_tens;
    else if (r_scan_pos == c_pos_ones) w_digit = r_ones;
    else                               w_digit = bus.static_bcd[{r_scan_pos, 2'b00} +: 4];
  end

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hc0;
      4'd1:    return 8'hf9;
      4'd2:    return 8'ha4;
      4'd3:    return 8'hb0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hf8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hff;
    endcase
  endfunction

  // Enable and segments share one register stage so they never disagree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_en <= '1;
      r_seg    <= 8'hff;
    end else if (r_state == ST_IDLE) begin
      r_led_en <= '1;
      r_seg    <= 8'hff;
    end else begin
      r_led_en <= ~(NUM_DIGITS'(1) << r_scan_pos);
      r_seg    <= seg_decode(w_digit);
    end
  end

  assign bus.led_en  = r_led_en;
  assign bus.seg     = r_seg;
  assign bus.running = (r_state == ST_RUN);
  assign bus.done    = r_done;

endmodule
`default_nettype wire
